enemy_sprite_arbiter: RTL and testbench
=======================================

# enemy_sprite_arbiter

Shares the single enemy sprite BRAM between several enemy object instances, so the design carries one copy of the sprite image however many enemies are on screen. Each cycle it grants one requesting enemy round-robin and drives that enemy's address into the BRAM. It tracks which requester owns each read in flight through the BRAM's fixed read latency. It returns the fetched pixel as alpha plus RGB, tagged with the owner's index.

## Interface
Parameters:
- N_REQ, 4: number of enemy requesters, 2..8
- ADDR_W, 11: sprite BRAM address width
- LATENCY, 1: BRAM read latency in cycles; 1 = douta registered once, 2 = BRAM output register enabled
- ID_W, 2: requester index width; equals clog2(N_REQ), minimum 1

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_i  in  N_REQ  read request, one bit per enemy
- addr_i  in  N_REQ*ADDR_W  packed addresses; requester k uses [k*ADDR_W +: ADDR_W]
- gnt_o  out  N_REQ  one-hot grant, same cycle as the accepted request
- bram_en_o  out  1  BRAM ena
- bram_addr_o  out  ADDR_W  BRAM addra
- bram_dout_i  in  `COLOR_RGB_DEPTH+1  BRAM douta; MSB = alpha, LSBs = RGB
- rvalid_o  out  1  read data valid
- rid_o  out  ID_W  requester index owning the current data
- rgb_alpha_o  out  1  bram_dout_i[MSB], qualified by rvalid_o
- vga_rgb_o  out  `COLOR_RGB_DEPTH  bram_dout_i[`COLOR_RGB_DEPTH-1:0], qualified by rvalid_o

## Operation
- Round-robin pointer ptr, reset value 0.
  - Winner: the first k with req_i[k]=1, searching ptr, ptr+1, ... modulo N_REQ.
  - On a grant to k: ptr <= (k+1) mod N_REQ.
  - No request: ptr holds.
- Grant path is combinational, so a request is granted in the same cycle it is presented:
  - gnt_o: one-hot of the winner, 0 if no request.
  - bram_en_o = |req_i.
  - bram_addr_o = addr_i slice of the winner.
  - bram_addr_o = 0 when there is no request.
- A requester may hold req_i high across cycles. Each granted cycle is one independent read.
- req_i deasserted in a cycle: that requester is not considered in that cycle.
- Read tracking: a shift pipeline of LATENCY stages, each stage {valid, id}.
  - Stage 0 loads {|req_i, winner index} every clock edge.
  - rvalid_o and rid_o come from the last stage.
- rgb_alpha_o and vga_rgb_o are direct slices of bram_dout_i. Consumers ignore them when rvalid_o=0.
- Back-to-back grants give one valid result per cycle. There are no bubbles and no backpressure.

## Timing
- Request presented and granted in cycle t, address sampled by the BRAM at the end of t: rvalid_o=1 with rid_o=winner in cycle t+LATENCY.
- Throughput: one read per cycle, sustained.
- Reset (asynchronous, active-high):
  - ptr=0, all pipeline stages cleared, so rvalid_o=0 and rid_o=0 immediately on assertion.
  - gnt_o=0, bram_en_o=0, bram_addr_o=0 while rst=1, regardless of req_i.
- Reset mid-operation: reads in flight are discarded. No rvalid_o pulse for them after release.
- First cycle after release: arbitration restarts from ptr=0.
- Wrap-around: a grant to N_REQ-1 sets ptr=0.
- Single requester active: granted every cycle. ptr advances past it each cycle, which does not change the outcome.
- Fairness: with all N_REQ requesting continuously, each requester is granted exactly once in every N_REQ consecutive cycles.

## Test plan
- N_REQ=4, LATENCY=1, only req_i=4'b0100 with addr 0x05 at cycle t:
  - gnt_o=4'b0100, bram_en_o=1, bram_addr_o=0x05 in cycle t.
  - rvalid_o=1, rid_o=2, vga_rgb_o/rgb_alpha_o matching BRAM model word 0x05 in cycle t+1.
- req_i=4'b1111 held from reset release: gnt_o sequence 0001,0010,0100,1000,0001...; rvalid_o continuously 1 after one cycle, with rid_o 0,1,2,3,0...
- req_i=4'b1010 held: grants alternate 0010, 1000. After the grant to 3, ptr=0 and the next winner is 1.
- LATENCY=2, three back-to-back single grants to 0, 3, 1: rvalid_o high for three consecutive cycles starting 2 cycles after the first grant, with rid_o 0, 3, 1.
- Reset mid-run:
  - Assert rst with two reads in flight: rvalid_o drops to 0 asynchronously, and gnt_o=0 while rst=1.
  - After release with req_i=4'b1111: the first grant is 0001 and no stale rvalid_o appears.
- req_i=0 for 5 cycles: bram_en_o=0, gnt_o=0, rvalid_o=0 after the pipeline drains, and ptr unchanged (verified by the next grant order).

Source files
------------

// File: rtl/enemy_sprite_arbiter_if.sv
// Bus between the enemy requesters, the shared sprite BRAM and the sprite arbiter.
`ifndef COLOR_RGB_DEPTH
`define COLOR_RGB_DEPTH 12
`endif

interface enemy_sprite_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 11,
    parameter int ID_W   = 2
);
    localparam int RGB_W = `COLOR_RGB_DEPTH;

    logic [N_REQ-1:0]        req_i;
    logic [N_REQ*ADDR_W-1:0] addr_i;
    logic [N_REQ-1:0]        gnt_o;
    logic                    bram_en_o;
    logic [ADDR_W-1:0]       bram_addr_o;
    logic [RGB_W:0]          bram_dout_i;
    logic                    rvalid_o;
    logic [ID_W-1:0]         rid_o;
    logic                    rgb_alpha_o;
    logic [RGB_W-1:0]        vga_rgb_o;

    modport slave (
        input  req_i, addr_i, bram_dout_i,
        output gnt_o, bram_en_o, bram_addr_o, rvalid_o, rid_o, rgb_alpha_o, vga_rgb_o
    );

    modport master (
        output req_i, addr_i, bram_dout_i,
        input  gnt_o, bram_en_o, bram_addr_o, rvalid_o, rid_o, rgb_alpha_o, vga_rgb_o
    );
endinterface

// File: rtl/enemy_sprite_arbiter.sv
// Round-robin sharing of the single enemy sprite BRAM; each returned pixel is
// tagged with the index of the enemy whose read produced it.
`ifndef COLOR_RGB_DEPTH
`define COLOR_RGB_DEPTH 12
`endif

module enemy_sprite_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 11,
    parameter int LATENCY = 1,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    enemy_sprite_arbiter_if.slave bus
);
    localparam int RGB_W = `COLOR_RGB_DEPTH;

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_next;
    logic [ID_W-1:0] win_idx;
    logic            win_found;

    logic            vld_p [LATENCY];
    logic [ID_W-1:0] id_p  [LATENCY];

    // Search starts at ptr and wraps; reset forces the grant path idle.
    always_comb begin
        int k;
        k         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= N_REQ) k = k - N_REQ;
            if (!win_found && bus.req_i[k]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(k);
            end
        end
        if (rst) begin
            win_found = 1'b0;
            win_idx   = '0;
        end
    end

    always_comb begin
        ptr_next = ptr;
        if (win_found) begin
            if (win_idx == ID_W'(N_REQ - 1)) ptr_next = '0;
            else                             ptr_next = win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= '0;
        else     ptr <= ptr_next;
    end

    always_comb begin
        bus.gnt_o = '0;
        if (win_found) bus.gnt_o[win_idx] = 1'b1;
    end

    assign bus.bram_en_o   = win_found;
    assign bus.bram_addr_o = win_found ? bus.addr_i[int'(win_idx)*ADDR_W +: ADDR_W] : '0;

    // p0: owner of the read issued this cycle; later stages follow the BRAM latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_p[i] <= 1'b0;
                id_p[i]  <= '0;
            end
        end else begin
            vld_p[0] <= win_found;
            id_p[0]  <= win_idx;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                id_p[i]  <= id_p[i-1];
            end
        end
    end

    // Output: last tracking stage lines up with the BRAM douta of the same read
    assign bus.rvalid_o    = vld_p[LATENCY-1];
    assign bus.rid_o       = id_p[LATENCY-1];
    assign bus.rgb_alpha_o = bus.bram_dout_i[RGB_W];
    assign bus.vga_rgb_o   = bus.bram_dout_i[RGB_W-1:0];

endmodule

// File: tb/tb_enemy_sprite_arbiter.sv
// Bench for enemy_sprite_arbiter: LATENCY=1 and LATENCY=2 instances share
// stimulus and are compared against a round-robin reference model.
`ifndef COLOR_RGB_DEPTH
`define COLOR_RGB_DEPTH 12
`endif

module tb_enemy_sprite_arbiter;
    localparam int N     = 4;
    localparam int AW    = 11;
    localparam int IW    = 2;
    localparam int RGB_W = `COLOR_RGB_DEPTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    enemy_sprite_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .ID_W(IW)) bus1 ();
    enemy_sprite_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .ID_W(IW)) bus2 ();

    enemy_sprite_arbiter #(.N_REQ(N), .ADDR_W(AW), .LATENCY(1), .ID_W(IW)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    enemy_sprite_arbiter #(.N_REQ(N), .ADDR_W(AW), .LATENCY(2), .ID_W(IW)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    // Sprite BRAM models: one with a single output register, one with two
    logic [RGB_W:0] mem [2**AW];
    logic [RGB_W:0] l2_stage;
    always_ff @(posedge clk) begin
        if (bus1.bram_en_o) bus1.bram_dout_i <= mem[bus1.bram_addr_o];
        if (bus2.bram_en_o) l2_stage <= mem[bus2.bram_addr_o];
        bus2.bram_dout_i <= l2_stage;
    end

    int n_vec = 0;
    int n_err = 0;

    int            ptr_m;
    logic          hv  [2];
    int            hid [2];
    logic [AW-1:0] ha  [2];
    logic [AW-1:0] a   [N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic clear_model();
        ptr_m = 0;
        for (int i = 0; i < 2; i++) begin
            hv[i] = 1'b0; hid[i] = 0; ha[i] = '0;
        end
    endtask

    task automatic drive(input logic [N-1:0] r, input int fa);
        for (int k = 0; k < N; k++) begin
            a[k] = (fa >= 0) ? AW'(fa) : AW'($urandom_range(0, 2**AW - 1));
            bus1.addr_i[k*AW +: AW] = a[k];
            bus2.addr_i[k*AW +: AW] = a[k];
        end
        bus1.req_i = r;
        bus2.req_i = r;
    endtask

    task automatic run_cycle(input logic [N-1:0] r, input int fa);
        int            w;
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        @(posedge clk);
        #1;
        drive(r, fa);
        @(negedge clk);
        w  = rr_pick(r, ptr_m);
        eg = (w < 0) ? '0 : N'(1 << w);
        ea = (w < 0) ? '0 : a[w];
        check_eq("gnt1", 32'(bus1.gnt_o), 32'(eg));
        check_eq("gnt2", 32'(bus2.gnt_o), 32'(eg));
        check_eq("en1", 32'(bus1.bram_en_o), 32'(w >= 0));
        check_eq("addr1", 32'(bus1.bram_addr_o), 32'(ea));
        check_eq("addr2", 32'(bus2.bram_addr_o), 32'(ea));
        check_eq("rvalid1", 32'(bus1.rvalid_o), 32'(hv[0]));
        check_eq("rvalid2", 32'(bus2.rvalid_o), 32'(hv[1]));
        if (hv[0]) begin
            check_eq("rid1", 32'(bus1.rid_o), 32'(hid[0]));
            check_eq("pix1", 32'({bus1.rgb_alpha_o, bus1.vga_rgb_o}), 32'(mem[ha[0]]));
        end
        if (hv[1]) begin
            check_eq("rid2", 32'(bus2.rid_o), 32'(hid[1]));
            check_eq("pix2", 32'({bus2.rgb_alpha_o, bus2.vga_rgb_o}), 32'(mem[ha[1]]));
        end
        hv[1] = hv[0]; hid[1] = hid[0]; ha[1] = ha[0];
        hv[0] = (w >= 0); hid[0] = (w < 0) ? 0 : w; ha[0] = ea;
        if (w >= 0) ptr_m = (w + 1) % N;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rvalid1"}, 32'(bus1.rvalid_o), 32'd0);
        check_eq({tag, "_rvalid2"}, 32'(bus2.rvalid_o), 32'd0);
        check_eq({tag, "_rid1"}, 32'(bus1.rid_o), 32'd0);
        check_eq({tag, "_rid2"}, 32'(bus2.rid_o), 32'd0);
        check_eq({tag, "_gnt1"}, 32'(bus1.gnt_o), 32'd0);
        check_eq({tag, "_en1"}, 32'(bus1.bram_en_o), 32'd0);
        check_eq({tag, "_addr1"}, 32'(bus1.bram_addr_o), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = (RGB_W+1)'($urandom);
        rst = 1'b1;
        drive(4'b1111, -1);
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        drive(4'b0000, -1);
        #1 rst = 1'b0;

        // single request from enemy 2 at address 0x05
        run_cycle(4'b0100, 5);
        repeat (5) run_cycle(4'b0000, -1);

        // reset with reads in flight
        repeat (3) run_cycle(4'b1111, -1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("hold");
        drive(4'b0000, -1);
        #1 rst = 1'b0;
        clear_model();

        repeat (9) run_cycle(4'b1111, -1);
        repeat (6) run_cycle(4'b1010, -1);
        repeat (5) run_cycle(4'b0000, -1);
        run_cycle(4'b0001, -1);
        run_cycle(4'b1000, -1);
        run_cycle(4'b0010, -1);
        repeat (3) run_cycle(4'b0000, -1);

        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] r;
            r = N'($urandom_range(0, 15));
            if (($urandom % 8) == 0) r = '0;
            run_cycle(r, -1);
        end
        repeat (3) run_cycle(4'b0000, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
